// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: sequential front end for the 4-to-1 gate-level mux.
// Holds a loaded word on the mux data inputs, steps the select lines
// through positions 0..3 one per clock, and registers the returned mux
// output as a framed serial bit stream.
// Optional feature: define PARITY_EN to append an even-parity bit per frame.
module mux_sel_sequencer #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [0:3] din,
  output logic       busy,
  output logic [0:3] d,
  output logic [0:1] s,
  input  logic       o_in,
  output logic       sout,
  output logic       sout_valid,
  output logic       done
);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP_WAIT} state_t;
`endif

  // Last gap count value; unreachable when GAP is 0.
  localparam logic [1:0] GAP_LAST = 2'((GAP == 0) ? 0 : GAP - 1);

  state_t     state;
  logic [1:0] k;
  logic [1:0] gap_cnt;
  logic       last_bit;

  // Marks the cycle whose edge emits the final valid bit of the frame.
  always_comb begin
    last_bit = 1'b0;
`ifdef PARITY_EN
    if (state == PAR) last_bit = 1'b1;
`else
    if (state == SHIFT && k == 2'd3) last_bit = 1'b1;
`endif
  end

  // Frame sequencer: load, shift four mux selections, optional parity, gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      gap_cnt    <= 2'd0;
      busy       <= 1'b0;
      d          <= 4'b0000;
      s          <= 2'b00;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            d     <= din;
            s     <= 2'b00;
            busy  <= 1'b1;
            k     <= 2'd0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sout       <= o_in;
          sout_valid <= 1'b1;
          k          <= k + 2'd1;
          if (k != 2'd3) begin
            // index = s[0] + 2*s[1] counts up: 00 -> 10 -> 01 -> 11
            s[0] <= ~s[0];
            s[1] <= s[1] ^ s[0];
          end
`ifdef PARITY_EN
          else begin
            state <= PAR;
          end
`endif
        end
`ifdef PARITY_EN
        PAR: begin
          sout       <= ^d;
          sout_valid <= 1'b1;
        end
`endif
        GAP_WAIT: begin
          gap_cnt <= gap_cnt + 2'd1;
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Frame tail: pulse done with the last bit, then gap or back to idle.
      if (last_bit) begin
        done    <= 1'b1;
        gap_cnt <= 2'd0;
        if (GAP > 0) begin
          state <= GAP_WAIT;
        end else begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: a GAP=0 and a GAP=2 instance share stimulus.
// A frame-offset model predicts every output each cycle; directed tests
// pin the model with literal bit patterns and frame spacings.
module tb_mux_sel_sequencer;

`ifdef PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, load;
  logic [0:3] din;

  logic       busy_w [2];
  logic [0:3] d_w    [2];
  logic [0:1] s_w    [2];
  logic       o_w    [2];
  logic       sout_w [2];
  logic       sv_w   [2];
  logic       done_w [2];

  always #5 clk = ~clk;

  function automatic logic mux4(input logic [0:3] dd, input logic [0:1] ss);
    logic [1:0] ix;
    ix = {ss[1], ss[0]};
    return dd[ix];
  endfunction

  assign o_w[0] = mux4(d_w[0], s_w[0]);
  assign o_w[1] = mux4(d_w[1], s_w[1]);

  mux_sel_sequencer #(.GAP(0)) u0 (
    .clk(clk), .rst(rst), .load(load), .din(din), .busy(busy_w[0]),
    .d(d_w[0]), .s(s_w[0]), .o_in(o_w[0]), .sout(sout_w[0]),
    .sout_valid(sv_w[0]), .done(done_w[0]));

  mux_sel_sequencer #(.GAP(2)) u1 (
    .clk(clk), .rst(rst), .load(load), .din(din), .busy(busy_w[1]),
    .d(d_w[1]), .s(s_w[1]), .o_in(o_w[1]), .sout(sout_w[1]),
    .sout_valid(sv_w[1]), .done(done_w[1]));

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gv(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Model: n = edges since the accepting edge E0 of the latest frame.
  int         n    [2];
  bit         have [2];
  logic [0:3] word [2];
  bit         started = 0;
  bit         rflag = 0;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started = 1;
      rflag = 1;
      for (int i = 0; i < 2; i++) begin
        n[i] = 100; have[i] = 0; word[i] = 4'b0000;
      end
    end else begin
      rflag = 0;
      for (int i = 0; i < 2; i++) begin
        if (!(n[i] < 4 + P + gv(i)) && load) begin
          n[i] = 0; have[i] = 1; word[i] = din;
        end else if (n[i] < 100) begin
          n[i] = n[i] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        int eidx, sidx;
        eidx = !have[i] ? 0 : (n[i] >= 3 ? 3 : n[i]);
        sidx = int'(s_w[i][0]) + 2 * int'(s_w[i][1]);
        chk($sformatf("busy%0d", i), int'(busy_w[i]), int'(n[i] < 4 + P + gv(i)));
        chk($sformatf("d%0d", i), int'(d_w[i]), int'(word[i]));
        chk($sformatf("sidx%0d", i), sidx, eidx);
        chk($sformatf("valid%0d", i), int'(sv_w[i]), int'(n[i] >= 1 && n[i] <= 4 + P));
        chk($sformatf("done%0d", i), int'(done_w[i]), int'(n[i] == 4 + P));
        if (n[i] >= 1 && n[i] <= 4)
          chk($sformatf("sout%0d", i), int'(sout_w[i]), int'(word[i][n[i]-1]));
        else if (n[i] == 5 && P == 1)
          chk($sformatf("par%0d", i), int'(sout_w[i]), int'(^word[i]));
        else if (rflag)
          chk($sformatf("rst_sout%0d", i), int'(sout_w[i]), 0);
      end
    end
  end

  // Capture of serial bits, done pulses and frame first-bit times.
  logic [7:0] cap0 = 8'h00;
  int         dcnt0 = 0;
  int         dcnt1 = 0;
  int         t0[$];
  int         t1[$];
  logic       pv0 = 1'b0, pv1 = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      if (sv_w[0] === 1'b1) cap0 = {cap0[6:0], sout_w[0]};
      if (done_w[0] === 1'b1) dcnt0++;
      if (done_w[1] === 1'b1) dcnt1++;
      if (sv_w[0] === 1'b1 && !pv0) t0.push_back(cyc);
      if (sv_w[1] === 1'b1 && !pv1) t1.push_back(cyc);
      pv0 = (sv_w[0] === 1'b1);
      pv1 = (sv_w[1] === 1'b1);
    end
  end

  task automatic do_load(input logic [0:3] w);
    @(negedge clk); load = 1'b1; din = w;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) && k < 60) begin
      @(negedge clk); k++;
    end
    if (k >= 60) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int dc0;
    rst = 1'b1; load = 1'b0; din = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_d", int'(d_w[0]), 0);
    chk("rst_s", int'(s_w[0]), 0);
    chk("rst_sout", int'(sout_w[0]), 0);
    chk("rst_valid", int'(sv_w[0]), 0);
    chk("rst_done", int'(done_w[0]), 0);
    rst = 1'b0;

    // Single frame 1011.
    dc0 = dcnt0; cap0 = 8'h00;
    do_load(4'b1011);
    wait_idle();
    chk("frame1_bits", int'(cap0[3:0]), int'(4'b1011));
    chk("frame1_done_cnt", dcnt0 - dc0, 1);

    // Load during frame ignored, then a fresh load after busy falls.
    cap0 = 8'h00;
    do_load(4'b1011);
    @(negedge clk); load = 1'b1; din = 4'b0100;
    @(negedge clk); load = 1'b0;
    chk("held_d", int'(d_w[0]), int'(4'b1011));
    wait_idle();
    chk("ignored_bits", int'(cap0[3:0]), int'(4'b1011));
    chk("ignored_d", int'(d_w[0]), int'(4'b1011));
    cap0 = 8'h00;
    do_load(4'b0100);
    wait_idle();
    chk("frame2_bits", int'(cap0[3:0]), int'(4'b0100));
    chk("s_holds_11", int'(s_w[0]), int'(2'b11));

`ifdef PARITY_EN
    cap0 = 8'h00;
    do_load(4'b0111);
    wait_idle();
    chk("par_0111", int'(cap0[4:0]), int'(5'b01111));
    cap0 = 8'h00;
    do_load(4'b1111);
    wait_idle();
    chk("par_1111", int'(cap0[4:0]), int'(5'b11110));
`endif

    // Back-to-back loads with load held high.
    t0.delete(); t1.delete();
    @(negedge clk); load = 1'b1; din = 4'b1010;
    repeat (20) @(negedge clk);
    load = 1'b0;
    wait_idle();
    chk("t1_frames", int'(t1.size() >= 2), 1);
    chk("t0_frames", int'(t0.size() >= 2), 1);
    if (t1.size() >= 2) chk("gap2_spacing", t1[1] - t1[0], 7 + P);
    if (t0.size() >= 2) chk("gap0_spacing", t0[1] - t0[0], 5 + P);

    // Reset in the middle of a frame.
    dc0 = dcnt0;
    do_load(4'b1101);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", int'(busy_w[0]), 0);
    chk("mid_d", int'(d_w[0]), 0);
    chk("mid_s", int'(s_w[0]), 0);
    chk("mid_sout", int'(sout_w[0]), 0);
    chk("mid_valid", int'(sv_w[0]), 0);
    chk("mid_done", int'(done_w[0]), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_no_done", dcnt0 - dc0, 0);
    cap0 = 8'h00;
    do_load(4'b0001);
    wait_idle();
    chk("after_rst_bits", int'(cap0[3:0]), int'(4'b0001));
    chk("after_rst_d", int'(d_w[0]), int'(4'b0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
